fb_scanout: RTL
===============

Name: fb_scanout

Overview:
- Downstream consumer of the game-state RAM port.
- Reads the 160x120 frame buffer that the greeting, playing and game-over stages write.
- Streams every pixel in raster order onto the VGA plot interface (x, y, colour, plot strobe).
- Drives the RAM read side (addr, wren), absorbs the fixed RAM read latency with a valid pipeline, and reports completion via a start/done handshake.

Parameters:
- CBIT, 11, colour MSB index; colour width is CBIT+1.
- WIDTH, 160, pixels per row.
- HEIGHT, 120, rows per frame.
- BASE_ADDR, 0, RAM word address of pixel (0,0).
- RD_LAT, 1, RAM clock edges from addr presented to q valid; legal range 1..3.

Ports:
- clock  in  1  system clock.
- resetn  in  1  reset; asynchronous assert, active-low.
- enable  in  1  high = may run; low while busy = abort.
- start  in  1  request one full-frame scan; sampled only in IDLE.
- key_en  in  1  enable colour-key skipping.
- key_color  in  CBIT+1  pixels equal to this value are not plotted when key_en=1.
- addr  out  15  RAM read address.
- wren  out  1  RAM write enable; constant 0.
- q  in  CBIT+1  RAM read data.
- VGA_X  out  8  pixel x.
- VGA_Y  out  7  pixel y.
- VGA_COLOR  out  CBIT+1  pixel colour.
- VGA_PLOT  out  1  write strobe for this pixel.
- busy  out  1  high in SCAN and DRAIN.
- done  out  1  one-cycle pulse at end of a completed frame.

Behaviour:
- Interface: one clock, clock. Reset resetn is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; counters 0; pipeline valids 0.
- States:
  - IDLE: start=1 and enable=1 at edge E0 -> SCAN, addr=BASE_ADDR, x=y=0.
  - SCAN: one address per cycle, raster order (x fastest).
    - addr increments by 1 each cycle; computed with a linear counter, no multiplier.
    - x wraps WIDTH-1 -> 0 with y+1.
    - After issuing address (WIDTH-1,HEIGHT-1) -> DRAIN.
  - DRAIN: waits RD_LAT+1 cycles for in-flight reads to emerge -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Pipeline: x, y and a valid bit are delayed RD_LAT stages alongside the RAM. On the edge where the delayed valid is 1, register VGA_X/VGA_Y/VGA_COLOR := delayed x, delayed y, q.
- VGA_PLOT timing:
  - VGA_PLOT = delayed valid AND NOT (key_en AND q==key_color).
  - First strobe is registered at edge E0+RD_LAT+1.
  - Last strobe at E0+RD_LAT+N, where N=WIDTH*HEIGHT.
  - done is high in the cycle after edge E0+RD_LAT+N+1.
  - Total for defaults: start-to-done = 19202 cycles.
- Keyed pixels: VGA_X/Y/COLOR still update; only VGA_PLOT stays 0.
- key_en and key_color are sampled live each cycle; they are not latched at start.
- Holding registers: VGA_X/Y/COLOR hold their last value when no pixel emerges. VGA_PLOT is 0 outside valid cycles.
- start while busy or in DONE: ignored, no queueing. start held high across DONE re-launches on the first IDLE cycle.
- enable=0 while busy: abort on that edge.
  - -> IDLE, all pipeline valids cleared, VGA_PLOT=0 from the next cycle.
  - No done pulse; addr returns to 0.
- enable=0 in IDLE: start is ignored.
- Asynchronous reset mid-scan: immediate return to reset values; no partial done.
- Width rules:
  - addr is 15 bits. BASE_ADDR+N-1 must be <= 32767; with defaults the last address is 19199.
  - x counter fits 8 bits, y counter fits 7 bits; WIDTH<=256, HEIGHT<=128.
  - The counter ceiling is checked by elaboration assertion.

Decomposition:
- Shared package (game-wide constants):
  - SCREEN_W=160, SCREEN_H=120, ADDR_W=15, default CBIT=11.
  - State encoding constants IDLE/SCAN/DRAIN/DONE (2 bits).
- One sub-module: fb_rd_delay.
  - Parameterised RD_LAT-stage shift register carrying {valid, x, y}.
  - Synchronous flush input, asynchronous active-low reset.
- Top block holds the FSM, address/x/y counters, key compare and output registers.

Test Plan:
- Defaults, RD_LAT=1, RAM model q=addr[11:0], one start pulse -> exactly 19200 VGA_PLOT strobes.
  - First strobe: (0,0,12'h000). Strobe 161: (0,1,12'h0A0). Last strobe: (159,119, 19199 mod 4096 = 12'hAFF).
  - done pulses once, 19202 cycles after start.
- WIDTH=4, HEIGHT=3, RD_LAT=3, BASE_ADDR=100 -> addr sequence 100..111 contiguous.
  - Plots (0,0)..(3,2) in order, each with q of the matching address.
  - done exactly 16 cycles after the start edge.
- WIDTH=4, HEIGHT=3, key_en=1, key_color=12'h005, q=addr -> 11 strobes; pixel (1,1) is not strobed.
- Deassert enable at cycle 50 of a default scan -> no strobes and no done afterwards, busy=0.
  - A new start then restarts from addr=0.
- start pulsed repeatedly during SCAN -> a single frame and a single done. start held high -> back-to-back frames separated by exactly one DONE and one IDLE cycle.
- resetn low for 1 cycle mid-DRAIN -> all outputs 0 asynchronously, no done, wren stays 0 throughout.

Source files
------------

// File: rtl/fb_scanout_pkg.sv
// Shared game-wide screen geometry, RAM address width and scan FSM encoding.
// Pure declarations; no logic, latency or flow control.
package fb_scanout_pkg;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int ADDR_W   = 15;
    localparam int CBIT_DEF = 11;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } pix_pos_t;
endpackage

// File: rtl/fb_rd_delay.sv
// Delays {valid, x, y} so pixel coordinates line up with the RAM read data.
// Latency LAT cycles; no backpressure, flush kills every in-flight valid on the next edge.
module fb_rd_delay
    import fb_scanout_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic     core_clk,
    input  logic     arst_n,
    input  logic     flush,
    input  logic     in_vld,
    input  pix_pos_t in_dat,
    output logic     out_vld,
    output pix_pos_t out_dat
);
    logic [LAT-1:0] vld_q;
    pix_pos_t       dat_q [LAT];

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) dat_q[i] <= '0;
        end else begin
            vld_q[0] <= in_vld && !flush;
            dat_q[0] <= in_dat;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1] && !flush;
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign out_vld = vld_q[LAT-1];
    assign out_dat = dat_q[LAT-1];
endmodule

// File: rtl/fb_scanout.sv
// Scans the frame buffer in raster order and plots each pixel on the VGA port.
// Plot lags the issued address by RD_LAT+1 cycles; no backpressure, enable low aborts the frame.
module fb_scanout
    import fb_scanout_pkg::*;
#(
    parameter int CBIT      = CBIT_DEF,
    parameter int WIDTH     = SCREEN_W,
    parameter int HEIGHT    = SCREEN_H,
    parameter int BASE_ADDR = 0,
    parameter int RD_LAT    = 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              enable,
    input  logic              start,
    input  logic              key_en,
    input  logic [CBIT:0]     key_color,
    output logic [ADDR_W-1:0] addr,
    output logic              wren,
    input  logic [CBIT:0]     q,
    output logic [X_W-1:0]    VGA_X,
    output logic [Y_W-1:0]    VGA_Y,
    output logic [CBIT:0]     VGA_COLOR,
    output logic              VGA_PLOT,
    output logic              busy,
    output logic              done
);
    if (WIDTH < 1 || WIDTH > 256 || HEIGHT < 1 || HEIGHT > 128 || RD_LAT < 1 || RD_LAT > 3 ||
        BASE_ADDR < 0 || BASE_ADDR + WIDTH * HEIGHT - 1 > 32767) begin : g_bad_cfg
        $error("fb_scanout: geometry, base address or read latency out of range");
    end

    localparam logic [X_W-1:0]    X_LAST     = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0]    Y_LAST     = Y_W'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] ADDR_BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT);

    state_t            state, state_nxt;
    logic [X_W-1:0]    x_cnt;
    logic [Y_W-1:0]    y_cnt;
    logic [1:0]        drain_cnt;
    logic              last_pix;
    logic              abort;
    logic              dly_vld;
    pix_pos_t          dly_dat;
    pix_pos_t          cur_pos;

    assign last_pix = (x_cnt == X_LAST) && (y_cnt == Y_LAST);
    assign abort    = !enable && (state == SCAN || state == DRAIN);
    assign cur_pos  = '{x: x_cnt, y: y_cnt};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && enable) state_nxt = SCAN;
            SCAN:    if (!enable) state_nxt = IDLE;
                     else if (last_pix) state_nxt = DRAIN;
            DRAIN:   if (!enable) state_nxt = IDLE;
                     else if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Address is a linear counter alongside x/y, so no row multiply is needed.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr      <= '0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            drain_cnt <= '0;
        end else begin
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            case (state)
                IDLE: begin
                    if (start && enable) begin
                        addr  <= ADDR_BASE;
                        x_cnt <= '0;
                        y_cnt <= '0;
                    end
                end
                SCAN: begin
                    if (abort) begin
                        addr  <= '0;
                        x_cnt <= '0;
                        y_cnt <= '0;
                    end else if (!last_pix) begin
                        addr <= addr + ADDR_W'(1);
                        if (x_cnt == X_LAST) begin
                            x_cnt <= '0;
                            y_cnt <= y_cnt + Y_W'(1);
                        end else begin
                            x_cnt <= x_cnt + X_W'(1);
                        end
                    end
                end
                default: begin
                    if (state_nxt == IDLE) begin
                        addr  <= '0;
                        x_cnt <= '0;
                        y_cnt <= '0;
                    end
                end
            endcase
        end
    end

    fb_rd_delay #(.LAT(RD_LAT)) u_rd_delay (
        .core_clk (clock),
        .arst_n   (resetn),
        .flush    (abort),
        .in_vld   (state == SCAN),
        .in_dat   (cur_pos),
        .out_vld  (dly_vld),
        .out_dat  (dly_dat)
    );

    // Keyed pixels still refresh X/Y/COLOR; only the strobe is suppressed.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            VGA_X     <= '0;
            VGA_Y     <= '0;
            VGA_COLOR <= '0;
            VGA_PLOT  <= 1'b0;
        end else begin
            if (dly_vld && !abort) begin
                VGA_X     <= dly_dat.x;
                VGA_Y     <= dly_dat.y;
                VGA_COLOR <= q;
            end
            VGA_PLOT <= dly_vld && !abort && !(key_en && (q == key_color));
        end
    end

    assign wren = 1'b0;
    assign busy = (state == SCAN) || (state == DRAIN);
    assign done = (state == DONE);
endmodule
